// File: rtl/md_pad_scanner.sv
// Mega Drive 3/6-button / Atari pad scanner for one DB9 port.
// Each frame interrupt runs an 8-phase select sequence, then decodes the samples once.
module md_pad_scanner #(
    parameter int unsigned PHASE_CYCLES = 280
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vertical_retrace_int_n,
    input  logic [5:0]  pad_in,
    output logic        sel_out,
    output logic [5:0]  joy_out,
    output logic [11:0] buttons,
    output logic [1:0]  pad_type,
    output logic        busy,
    output logic        valid
);

    localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] CycLast = CW'(PHASE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e      r_state;
    logic [5:0]  r_pad_meta;
    logic [5:0]  r_ps;
    logic        r_vr_q;
    logic [2:0]  r_phase;
    logic [CW-1:0] r_cyc;

    // Only the sample bits the decoder consumes are kept.
    logic [1:0]  r_s0_id;
    logic [1:0]  r_s0_as;
    logic [5:0]  r_s1;
    logic [3:0]  r_s4_dir;
    logic [3:0]  r_s5_ext;

    logic        r_sel;
    logic [5:0]  r_joy;
    logic [11:0] r_buttons;
    logic [1:0]  r_pad_type;
    logic        r_busy;
    logic        r_valid;

    logic        w_fall;
    logic        w_md;
    logic        w_six;
    logic        w_a;
    logic        w_b;
    logic        w_start;
    logic [3:0]  w_ext;
    logic [5:0]  w_joy;
    logic [11:0] w_buttons;
    logic [1:0]  w_pad_type;

    assign w_fall = r_vr_q & ~vertical_retrace_int_n;

    always_comb begin
        w_md    = (r_s0_id == 2'b00);
        w_six   = w_md && (r_s4_dir == 4'b0000);
        w_a     = ~r_s0_as[0];
        w_b     = ~r_s1[4];
        w_start = ~r_s0_as[1];
        // {mode, x, y, z}
        w_ext   = w_six ? ~{r_s5_ext[0], r_s5_ext[1], r_s5_ext[2], r_s5_ext[3]} : 4'b0000;
        if (!w_md) begin
            w_buttons  = {5'b00000, ~r_s1[5], ~r_s1[4], 1'b0, ~r_s1[3:0]};
            w_joy      = r_s1;
            w_pad_type = 2'b00;
        end else begin
            w_buttons  = {w_ext, w_start, ~r_s1[5], w_b, w_a, ~r_s1[3:0]};
            w_joy      = {r_s1[5], ~(w_a | w_b), r_s1[3:0]};
            w_pad_type = w_six ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_pad_meta <= 6'h3F;
            r_ps       <= 6'h3F;
            r_vr_q     <= 1'b1;
            r_phase    <= 3'd0;
            r_cyc      <= '0;
            r_s0_id    <= 2'b11;
            r_s0_as    <= 2'b11;
            r_s1       <= 6'h3F;
            r_s4_dir   <= 4'hF;
            r_s5_ext   <= 4'hF;
            r_sel      <= 1'b1;
            r_joy      <= 6'h3F;
            r_buttons  <= 12'h000;
            r_pad_type <= 2'b00;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_pad_meta <= pad_in;
            r_ps       <= r_pad_meta;
            r_vr_q     <= vertical_retrace_int_n;
            r_valid    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_fall) begin
                        r_state <= StScan;
                        r_busy  <= 1'b1;
                        r_phase <= 3'd0;
                        r_cyc   <= '0;
                        r_sel   <= 1'b0;
                    end
                end
                StScan: begin
                    if (r_cyc == CycLast) begin
                        case (r_phase)
                            3'd0: begin
                                r_s0_id <= r_ps[1:0];
                                r_s0_as <= r_ps[5:4];
                            end
                            3'd1: r_s1     <= r_ps;
                            3'd4: r_s4_dir <= r_ps[3:0];
                            3'd5: r_s5_ext <= r_ps[3:0];
                            default: ;
                        endcase
                        r_cyc <= '0;
                        if (r_phase == 3'd7) begin
                            // Samples 0..5 are already stored, so decode commits at this edge.
                            r_state    <= StIdle;
                            r_busy     <= 1'b0;
                            r_sel      <= 1'b1;
                            r_valid    <= 1'b1;
                            r_joy      <= w_joy;
                            r_buttons  <= w_buttons;
                            r_pad_type <= w_pad_type;
                            r_phase    <= 3'd0;
                        end else begin
                            r_phase <= r_phase + 3'd1;
                            r_sel   <= ~r_phase[0];
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign sel_out  = r_sel;
    assign joy_out  = r_joy;
    assign buttons  = r_buttons;
    assign pad_type = r_pad_type;
    assign busy     = r_busy;
    assign valid    = r_valid;

endmodule

// File: tb/tb_md_pad_scanner.sv
// Directed bench for md_pad_scanner with a behavioural Atari / 3-button / 6-button pad.
module tb_md_pad_scanner;

    localparam int unsigned PC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vr_n;
    logic [5:0]  pad_in;
    logic        sel_out;
    logic [5:0]  joy_out;
    logic [11:0] buttons;
    logic [1:0]  pad_type;
    logic        busy;
    logic        valid;

    int errors = 0;
    int checks = 0;

    int          model_mode = 0;
    logic [11:0] model_btn = 12'h000;
    logic [5:0]  atari_val = 6'h3F;
    logic        model_clr = 1'b0;
    int          low_cnt = 0;

    int cyc_cnt = 0;
    int vcount = 0;
    int vcyc = 0;
    int e_mark = 0;
    int v0 = 0;

    always #5 clk = ~clk;

    md_pad_scanner #(.PHASE_CYCLES(PC)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .vertical_retrace_int_n (vr_n),
        .pad_in                 (pad_in),
        .sel_out                (sel_out),
        .joy_out                (joy_out),
        .buttons                (buttons),
        .pad_type               (pad_type),
        .busy                   (busy),
        .valid                  (valid)
    );

    // Pad-internal count of select-low periods; cleared to mimic the pad's timeout.
    always @(negedge sel_out or posedge model_clr) begin
        if (model_clr) low_cnt = 0;
        else low_cnt = low_cnt + 1;
    end

    always_comb begin
        pad_in = 6'h3F;
        if (model_mode == 0) begin
            pad_in = atari_val;
        end else if (!sel_out) begin
            if (model_mode == 2 && low_cnt == 3)
                pad_in = {~model_btn[7], ~model_btn[4], 4'b0000};
            else if (model_mode == 2 && low_cnt == 4)
                pad_in = {~model_btn[7], ~model_btn[4], 4'b1111};
            else
                pad_in = {~model_btn[7], ~model_btn[4], ~model_btn[3], ~model_btn[2], 2'b00};
        end else begin
            if (model_mode == 2 && low_cnt == 3)
                pad_in = {~model_btn[6], ~model_btn[5], ~model_btn[8], ~model_btn[9],
                          ~model_btn[10], ~model_btn[11]};
            else
                pad_in = {~model_btn[6], ~model_btn[5], ~model_btn[3:0]};
        end
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcount <= vcount + 1;
            vcyc   <= cyc_cnt;
        end
    end

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the falling clock edge right after detect edge E.
    task automatic start_scan;
        @(negedge clk);
        model_clr = 1'b1;
        #1 model_clr = 1'b0;
        vr_n   = 1'b0;
        e_mark = cyc_cnt + 1;
        v0     = vcount;
        @(negedge clk);
        vr_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        vr_n    = 1'b1;
        run(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_sel", 12'(sel_out), 12'h1);
        check("rst_joy", 12'(joy_out), 12'h03F);
        check("rst_buttons", buttons, 12'h000);
        check("rst_type", 12'(pad_type), 12'h0);
        check("rst_busy", 12'(busy), 12'h0);
        run(20);
        check("no_spurious_valid", 12'(vcount), 12'h0);

        // Atari stick
        model_mode = 0;
        atari_val  = 6'b101110;
        start_scan();
        check("atari_busy", 12'(busy), 12'h1);
        check("atari_sel0", 12'(sel_out), 12'h0);
        run(35);
        check("atari_vcount", 12'(vcount - v0), 12'h1);
        check("atari_latency", 12'(vcyc - e_mark), 12'd32);
        check("atari_joy", 12'(joy_out), 12'b101110);
        check("atari_type", 12'(pad_type), 12'h0);
        check("atari_buttons", buttons, 12'h021);
        check("atari_busy_end", 12'(busy), 12'h0);

        // 3-button pad, A+Start+Up
        model_mode = 1;
        model_btn  = 12'h098;
        start_scan();
        for (int i = 0; i <= 32; i++) begin
            logic exp_sel;
            exp_sel = (i < 32) ? 1'(((i / 4) % 2)) : 1'b1;
            check($sformatf("md3_sel_%0d", i), 12'(sel_out), 12'(exp_sel));
            @(negedge clk);
        end
        run(2);
        check("md3_vcount", 12'(vcount - v0), 12'h1);
        check("md3_type", 12'(pad_type), 12'h1);
        check("md3_buttons", buttons, 12'h098);
        check("md3_joy", 12'(joy_out), 12'b100111);

        // 6-button pad, X+Mode
        model_mode = 2;
        model_btn  = 12'hC00;
        start_scan();
        run(35);
        check("md6_vcount", 12'(vcount - v0), 12'h1);
        check("md6_type", 12'(pad_type), 12'h2);
        check("md6_buttons", buttons, 12'hC00);
        check("md6_joy", 12'(joy_out), 12'h03F);

        // Second falling edge inside a scan is ignored
        start_scan();
        run(10);
        vr_n = 1'b0;
        @(negedge clk);
        vr_n = 1'b1;
        run(30);
        check("dbl_vcount", 12'(vcount - v0), 12'h1);
        check("dbl_latency", 12'(vcyc - e_mark), 12'd32);
        check("dbl_busy", 12'(busy), 12'h0);
        start_scan();
        run(35);
        check("after_vcount", 12'(vcount - v0), 12'h1);
        check("after_latency", 12'(vcyc - e_mark), 12'd32);

        // Reset during phase 5
        start_scan();
        run(21);
        reset_n = 1'b0;
        #1;
        check("midrst_sel", 12'(sel_out), 12'h1);
        check("midrst_busy", 12'(busy), 12'h0);
        check("midrst_buttons", buttons, 12'h000);
        check("midrst_joy", 12'(joy_out), 12'h03F);
        @(negedge clk);
        reset_n = 1'b1;
        run(3);
        start_scan();
        run(35);
        check("postrst_vcount", 12'(vcount - v0), 12'h1);
        check("postrst_type", 12'(pad_type), 12'h2);
        check("postrst_buttons", buttons, 12'hC00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
